// File: rtl/ldpc_layered_dec_if.sv
// Handshake bundle for the layered LDPC decoder: LLR frame in, hard codeword result out.
interface ldpc_layered_dec_if #(
    parameter int WIDTH  = 8,
    parameter int N      = 6,
    parameter int ITER_W = 8
);
    logic [N*WIDTH-1:0] llr_in;
    logic               in_valid;
    logic               in_ready;
    logic [ITER_W-1:0]  max_iter;
    logic [N-1:0]       cw_out;
    logic               converged;
    logic [ITER_W-1:0]  iter_count;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output llr_in, in_valid, max_iter, out_ready,
        input  in_ready, cw_out, converged, iter_count, out_valid
    );

    modport slave (
        input  llr_in, in_valid, max_iter, out_ready,
        output in_ready, cw_out, converged, iter_count, out_valid
    );
endinterface

// File: rtl/ldpc_layered_dec.sv
// Layered offset-min-sum LDPC decoder: one check row per cycle, early stop on zero syndrome.
module ldpc_layered_dec #(
    parameter int             WIDTH    = 8,
    parameter int             N        = 6,
    parameter int             M        = 3,
    parameter logic [M*N-1:0] H_MATRIX = 18'b100101_010110_001011,
    parameter int             OFFSET   = 1,
    parameter int             ITER_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    ldpc_layered_dec_if.slave dec_io
);
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int LIM_I = (2 ** (WIDTH - 1)) - 1;
    localparam logic signed [WIDTH:0]   LIM     = LIM_I[WIDTH:0];
    localparam logic signed [WIDTH-1:0] LIM_N   = LIM_I[WIDTH-1:0];
    localparam logic [WIDTH-1:0]        MAG_MAX = LIM_I[WIDTH-1:0];
    localparam logic [WIDTH-1:0]        OFF     = WIDTH'(OFFSET);

    typedef enum logic [1:0] {IDLE, CHECK, CN, DONE} state_e;

    // Symmetric saturation: -2^(WIDTH-1) is never produced, so negation cannot overflow.
    function automatic logic signed [WIDTH-1:0] clip(input logic signed [WIDTH:0] x);
        if (x > LIM)  return LIM_N;
        if (x < -LIM) return -LIM_N;
        return x[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH:0] ext(input logic signed [WIDTH-1:0] x);
        return {x[WIDTH-1], x};
    endfunction

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [ITER_W-1:0]       iter_q, iter_d, max_q, max_d;
    logic [N-1:0]            cw_q, cw_d;
    logic                    conv_q, conv_d;
    logic signed [WIDTH-1:0] post_q [N];
    logic signed [WIDTH-1:0] post_d [N];
    logic signed [WIDTH-1:0] c2v_q [M][N];
    logic signed [WIDTH-1:0] c2v_d [M][N];

    logic [N-1:0]            h_rows [M];
    logic [N-1:0]            h_row, hd;
    logic                    syn_zero, cn_active;
    logic signed [WIDTH-1:0] v2c [N];
    logic signed [WIDTH-1:0] c2v_new [N];
    logic signed [WIDTH-1:0] post_new [N];
    logic [WIDTH-1:0]        absv [N];

    always_comb begin
        for (int r = 0; r < M; r++)
            for (int j = 0; j < N; j++)
                h_rows[r][j] = H_MATRIX[r*N + j];
    end

    assign h_row = h_rows[row_q];

    always_comb begin
        syn_zero = 1'b1;
        for (int j = 0; j < N; j++) hd[j] = post_q[j][WIDTH-1];
        for (int r = 0; r < M; r++) syn_zero = syn_zero & ~(^(h_rows[r] & hd));
    end

    // Check-node update for the current row; the exclusive min/sign is a direct O(N^2) scan.
    always_comb begin
        int               deg;
        logic [WIDTH-1:0] mn;
        logic [WIDTH-1:0] mag;
        logic             sgn;
        deg = 0;
        for (int j = 0; j < N; j++) begin
            if (h_row[j]) deg++;
            v2c[j]  = clip(ext(post_q[j]) - ext(c2v_q[row_q][j]));
            absv[j] = v2c[j][WIDTH-1] ? WIDTH'(-v2c[j]) : WIDTH'(v2c[j]);
        end
        for (int j = 0; j < N; j++) begin
            mn  = MAG_MAX;
            sgn = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (h_row[k] && (k != j)) begin
                    if (absv[k] < mn) mn = absv[k];
                    sgn = sgn ^ v2c[k][WIDTH-1];
                end
            end
            mag         = (mn > OFF) ? mn - OFF : '0;
            c2v_new[j]  = sgn ? -$signed(mag) : $signed(mag);
            post_new[j] = clip(ext(v2c[j]) + ext(c2v_new[j]));
        end
        cn_active = (deg >= 2);
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        iter_d  = iter_q;
        max_d   = max_q;
        cw_d    = cw_q;
        conv_d  = conv_q;
        post_d  = post_q;
        c2v_d   = c2v_q;
        unique case (state_q)
            IDLE: begin
                if (dec_io.in_valid) begin
                    for (int j = 0; j < N; j++)
                        post_d[j] = clip(ext($signed(dec_io.llr_in[j*WIDTH +: WIDTH])));
                    for (int r = 0; r < M; r++)
                        for (int j = 0; j < N; j++)
                            c2v_d[r][j] = '0;
                    iter_d  = '0;
                    max_d   = dec_io.max_iter;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (syn_zero || (iter_q == max_q)) begin
                    state_d = DONE;
                    conv_d  = syn_zero;
                    cw_d    = hd;
                end else begin
                    state_d = CN;
                    row_d   = '0;
                end
            end
            CN: begin
                for (int j = 0; j < N; j++) begin
                    if (h_row[j]) begin
                        if (cn_active) begin
                            c2v_d[row_q][j] = c2v_new[j];
                            post_d[j]       = post_new[j];
                        end else begin
                            c2v_d[row_q][j] = '0;
                        end
                    end
                end
                if (row_q == ROW_W'(M - 1)) begin
                    iter_d  = iter_q + ITER_W'(1);
                    state_d = CHECK;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            DONE: begin
                if (dec_io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            iter_q  <= '0;
            max_q   <= '0;
            cw_q    <= '0;
            conv_q  <= 1'b0;
            for (int j = 0; j < N; j++) post_q[j] <= '0;
            for (int r = 0; r < M; r++)
                for (int j = 0; j < N; j++)
                    c2v_q[r][j] <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            iter_q  <= iter_d;
            max_q   <= max_d;
            cw_q    <= cw_d;
            conv_q  <= conv_d;
            post_q  <= post_d;
            c2v_q   <= c2v_d;
        end
    end

    assign dec_io.in_ready   = (state_q == IDLE);
    assign dec_io.out_valid  = (state_q == DONE);
    assign dec_io.cw_out     = cw_q;
    assign dec_io.converged  = conv_q;
    assign dec_io.iter_count = iter_q;
endmodule

// File: tb/tb_ldpc_layered_dec.sv
// Directed bench for ldpc_layered_dec on the default 3x6 code with hand-derived results.
module tb_ldpc_layered_dec;
    localparam int WIDTH  = 8;
    localparam int N      = 6;
    localparam int M      = 3;
    localparam int ITER_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ldpc_layered_dec_if #(.WIDTH(WIDTH), .N(N), .ITER_W(ITER_W)) bus ();

    ldpc_layered_dec #(
        .WIDTH(WIDTH), .N(N), .M(M),
        .H_MATRIX(18'b100101_010110_001011),
        .OFFSET(1), .ITER_W(ITER_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dec_io(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*WIDTH-1:0] pk(input int l0, input int l1, input int l2,
                                              input int l3, input int l4, input int l5);
        logic [N*WIDTH-1:0] v;
        v[0*WIDTH +: WIDTH] = WIDTH'(l0);
        v[1*WIDTH +: WIDTH] = WIDTH'(l1);
        v[2*WIDTH +: WIDTH] = WIDTH'(l2);
        v[3*WIDTH +: WIDTH] = WIDTH'(l3);
        v[4*WIDTH +: WIDTH] = WIDTH'(l4);
        v[5*WIDTH +: WIDTH] = WIDTH'(l5);
        return v;
    endfunction

    // Latency = number of cycles from the accept cycle to the first cycle with out_valid high.
    task automatic send(input logic [N*WIDTH-1:0] llr, input int mi, output int lat);
        @(negedge clk);
        chk("in_ready_idle", bus.in_ready, 1);
        bus.llr_in   = llr;
        bus.max_iter = ITER_W'(mi);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        chk("out_valid_seen", bus.out_valid, 1);
    endtask

    task automatic expect_res(input string tag, input int lat, input int elat,
                              input logic [N-1:0] ecw, input logic econv, input int eit);
        chk({tag, "_lat"},  lat,            elat);
        chk({tag, "_cw"},   bus.cw_out,     ecw);
        chk({tag, "_conv"}, bus.converged,  econv);
        chk({tag, "_iter"}, bus.iter_count, eit);
    endtask

    task automatic drain();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("in_ready_after_hs",  bus.in_ready,  1);
        chk("out_valid_after_hs", bus.out_valid, 0);
    endtask

    initial begin
        int lat;
        logic [N*WIDTH-1:0] t1, t2;
        bus.llr_in    = '0;
        bus.in_valid  = 1'b0;
        bus.max_iter  = '0;
        bus.out_ready = 1'b0;
        t1 = pk(10, 10, 10, 10, 10, 10);
        t2 = pk(-2, 10, 10, 10, 10, 10);

        #12;
        chk("rst_in_ready",  bus.in_ready,   1);
        chk("rst_out_valid", bus.out_valid,  0);
        chk("rst_cw",        bus.cw_out,     0);
        chk("rst_conv",      bus.converged,  0);
        chk("rst_iter",      bus.iter_count, 0);
        @(negedge clk);
        rst = 1'b0;

        send(t1, 5, lat);
        expect_res("t1", lat, 2, 6'b000000, 1'b1, 0);
        drain();

        send(t2, 5, lat);
        expect_res("t2", lat, 6, 6'b000000, 1'b1, 1);
        drain();

        send(t2, 0, lat);
        expect_res("t3", lat, 2, 6'b000001, 1'b0, 0);
        drain();

        // Row-1 sums reach 198 and must saturate to +127 rather than wrap negative.
        send(pk(-2, 100, 100, 100, 100, 100), 5, lat);
        expect_res("sat", lat, 6, 6'b000000, 1'b1, 1);
        drain();

        send(pk(-127, -127, 1, 1, 1, 1), 3, lat);
        expect_res("t4", lat, 2 + 3 * (M + 1), 6'b000011, 1'b0, 3);
        drain();

        send(pk(-128, 10, 10, 10, 10, 10), 1, lat);
        expect_res("t5", lat, 6, 6'b000001, 1'b0, 1);
        drain();

        send(t2, 5, lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.llr_in   = pk(-50, -50, -50, -50, -50, -50);
            bus.max_iter = '0;
            bus.in_valid = (c % 2 == 0);
            chk("hold_out_valid", bus.out_valid,  1);
            chk("hold_in_ready",  bus.in_ready,   0);
            chk("hold_cw",        bus.cw_out,     6'b000000);
            chk("hold_conv",      bus.converged,  1);
            chk("hold_iter",      bus.iter_count, 1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("hold_end_valid", bus.out_valid, 1);
        drain();

        @(negedge clk);
        bus.llr_in   = t2;
        bus.max_iter = ITER_W'(5);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("busy_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid,  0);
        chk("midrst_in_ready",  bus.in_ready,   1);
        chk("midrst_iter",      bus.iter_count, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("aborted_no_output", bus.out_valid, 0);
        end

        send(t1, 5, lat);
        expect_res("post_rst", lat, 2, 6'b000000, 1'b1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
